// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between two requesters.
// Each access runs IDLE -> ACCESS -> (WAIT for reads) -> IDLE, so only one
// transaction is ever outstanding.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; without it
// port 0 always wins contention and no pointer logic exists.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1    // legal 1..3
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  // Two bits are enough for latencies up to 3.
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;      // port that owns the current access
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              win;               // 1 = port 1 wins this IDLE cycle

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;                   // preferred port under contention

  // Round-robin choice: preferred port on contention, otherwise the lone requester.
  always_comb begin
    win   = m1_req & ~m0_req;
    ptr_d = ptr_q;
    if (m0_req && m1_req) begin
      win = ptr_q;
    end
    if (state_q == IDLE && (m0_req || m1_req)) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, flips on every grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign win = m1_req & ~m0_req;
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d   = win;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          we_d    = win ? m1_we    : m0_we;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // we_q still holds the winner's direction during this cycle.
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'd1;
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          if (sel_q) begin
            rdata1_d = mem_rdata;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = mem_rdata;
            rv0_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, hand-written corner sequences and a random
// phase checked against a transaction-level timing model of the arbiter.
// Two instances: d1 with READ_LATENCY = 1, d3 with READ_LATENCY = 3.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int RL1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        d1_m0_req, d1_m0_we, d1_m1_req, d1_m1_we;
  logic [31:0] d1_m0_addr, d1_m0_wdata, d1_m1_addr, d1_m1_wdata;
  logic        d1_m0_gnt, d1_m0_rvalid, d1_m1_gnt, d1_m1_rvalid, d1_mem_we, d1_busy;
  logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

  logic        d3_m0_req, d3_m0_we, d3_m1_req, d3_m1_we;
  logic [31:0] d3_m0_addr, d3_m0_wdata, d3_m1_addr, d3_m1_wdata;
  logic        d3_m0_gnt, d3_m0_rvalid, d3_m1_gnt, d3_m1_rvalid, d3_mem_we, d3_busy;
  logic [31:0] d3_m0_rdata, d3_m1_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) u_d1 (
    .clk(clk), .rst(rst),
    .m0_req(d1_m0_req), .m0_addr(d1_m0_addr), .m0_wdata(d1_m0_wdata), .m0_we(d1_m0_we),
    .m0_gnt(d1_m0_gnt), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
    .m1_req(d1_m1_req), .m1_addr(d1_m1_addr), .m1_wdata(d1_m1_wdata), .m1_we(d1_m1_we),
    .m1_gnt(d1_m1_gnt), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_we(d1_mem_we),
    .mem_rdata(d1_mem_rdata), .busy(d1_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) u_d3 (
    .clk(clk), .rst(rst),
    .m0_req(d3_m0_req), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata), .m0_we(d3_m0_we),
    .m0_gnt(d3_m0_gnt), .m0_rvalid(d3_m0_rvalid), .m0_rdata(d3_m0_rdata),
    .m1_req(d3_m1_req), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata), .m1_we(d3_m1_we),
    .m1_gnt(d3_m1_gnt), .m1_rvalid(d3_m1_rvalid), .m1_rdata(d3_m1_rdata),
    .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata), .mem_we(d3_mem_we),
    .mem_rdata(d3_mem_rdata), .busy(d3_busy)
  );

  // RAM models (64 words, word index = addr[5:0]); bench loads through ld_*.
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] ram1 [64];
  logic [31:0] ram3 [64];
  logic [31:0] q1, p3a, p3b, p3c;

  always @(posedge clk) begin
    if (ld_en) ram1[ld_addr] <= ld_data;
    else if (d1_mem_we) ram1[d1_mem_addr[5:0]] <= d1_mem_wdata;
    q1 <= ram1[d1_mem_addr[5:0]];
  end
  assign d1_mem_rdata = q1;

  always @(posedge clk) begin
    if (ld_en) ram3[ld_addr] <= ld_data;
    else if (d3_mem_we) ram3[d3_mem_addr[5:0]] <= d3_mem_wdata;
    p3a <= ram3[d3_mem_addr[5:0]];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign d3_mem_rdata = p3c;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [6];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic ram_load(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic idle_all();
    d1_m0_req = 0; d1_m1_req = 0; d3_m0_req = 0; d3_m1_req = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // One isolated transaction on d1, arbiter idle beforehand.
  task automatic apply_txn(input vec_t v);
    logic rv_exp;
    if (v.port) begin
      d1_m1_req = 1; d1_m1_addr = v.addr; d1_m1_wdata = v.wdata; d1_m1_we = v.we;
    end else begin
      d1_m0_req = 1; d1_m0_addr = v.addr; d1_m0_wdata = v.wdata; d1_m0_we = v.we;
    end
    tick();
    chk("txn_gnt", 64'({d1_m0_gnt, d1_m1_gnt}), 64'(v.port ? 2'b01 : 2'b10));
    chk("txn_bus", {d1_mem_addr, d1_mem_wdata}, {v.addr, v.wdata});
    chk("txn_we_busy", 64'({d1_mem_we, d1_busy}), 64'({v.we, 1'b1}));
    d1_m0_req = 0; d1_m1_req = 0;
    for (int d = 1; d <= RL1 + 1; d++) begin
      tick();
      rv_exp = !v.we && (d == RL1 + 1);
      chk("txn_rvalid", 64'({d1_m0_rvalid, d1_m1_rvalid}),
          64'({rv_exp && !v.port, rv_exp && v.port}));
      chk("txn_we_busy_after", 64'({d1_mem_we, d1_busy}), 64'({1'b0, !v.we && d <= RL1}));
    end
    if (!v.we) chk("txn_rdata", 64'(v.port ? d1_m1_rdata : d1_m0_rdata), 64'(v.exp_rdata));
    $display("txn port %0d we %0d addr %h wdata %h", v.port, v.we, v.addr, v.wdata);
  endtask

  // Random phase: requesters follow the protocol; the model predicts, per edge,
  // grants, bus contents, busy and read returns from the latency rules.
  task automatic random_phase(input int n);
    int          free_at, rv_edge;
    logic        rv_port, ptr, w, granted, ebusy, ewe;
    logic [1:0]  eg, erv;
    logic [31:0] rv_val, e_addr, e_wdata, e_rd0, e_rd1, v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ram_load(6'(i), v);
      ref_mem[i] = v;
    end
    do_reset();
    free_at = 0; rv_edge = -1; rv_port = 0; rv_val = '0; ptr = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      eg = 2'b00; erv = 2'b00; ewe = 1'b0; granted = 1'b0;
      if (k == rv_edge) begin
        if (rv_port) begin erv = 2'b01; e_rd1 = rv_val; end
        else begin erv = 2'b10; e_rd0 = rv_val; end
      end
      if (k >= free_at && (d1_m0_req || d1_m1_req)) begin
        granted = 1'b1;
        w = (d1_m0_req && d1_m1_req) ? (RR ? ptr : 1'b0) : d1_m1_req;
        ptr = ~ptr;
        eg = w ? 2'b01 : 2'b10;
        e_addr  = w ? d1_m1_addr  : d1_m0_addr;
        e_wdata = w ? d1_m1_wdata : d1_m0_wdata;
        ewe     = w ? d1_m1_we    : d1_m0_we;
        if (ewe) begin
          ref_mem[e_addr[5:0]] = e_wdata;
          free_at = k + 2;
        end else begin
          rv_edge = k + RL1 + 1;
          rv_port = w;
          rv_val  = ref_mem[e_addr[5:0]];
          free_at = k + RL1 + 2;
        end
        $display("rnd cycle %0d grant port %0d we %0d addr %h", k, w, ewe, e_addr);
      end
      ebusy = (k <= free_at - 2);
      chk("rnd_ctrl", 64'({d1_m0_gnt, d1_m1_gnt, d1_m0_rvalid, d1_m1_rvalid, d1_busy, d1_mem_we}),
          64'({eg, erv, ebusy, ewe}));
      chk("rnd_bus", {d1_mem_addr, d1_mem_wdata}, {e_addr, e_wdata});
      chk("rnd_rdata", {d1_m0_rdata, d1_m1_rdata}, {e_rd0, e_rd1});
      // Requester behaviour for the next edge.
      if (granted && !w) d1_m0_req = 0;
      else if (d1_m0_req) begin if ($urandom_range(9) == 0) d1_m0_req = 0; end
      else if ($urandom_range(2) == 0) begin
        d1_m0_req = 1; d1_m0_addr = 32'($urandom_range(63));
        d1_m0_we = 1'($urandom_range(1)); d1_m0_wdata = $urandom;
      end
      if (granted && w) d1_m1_req = 0;
      else if (d1_m1_req) begin if ($urandom_range(9) == 0) d1_m1_req = 0; end
      else if ($urandom_range(2) == 0) begin
        d1_m1_req = 1; d1_m1_addr = 32'($urandom_range(63));
        d1_m1_we = 1'($urandom_range(1)); d1_m1_wdata = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{port: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    tbl[1] = '{port: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'h12345678, exp_rdata: 32'h0};
    tbl[2] = '{port: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h5,        exp_rdata: 32'h12345678};
    tbl[3] = '{port: 1'b0, we: 1'b1, addr: 32'h30, wdata: 32'hA5A5A5A5, exp_rdata: 32'h0};
    tbl[4] = '{port: 1'b0, we: 1'b0, addr: 32'h30, wdata: 32'h7,        exp_rdata: 32'hA5A5A5A5};
    tbl[5] = '{port: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};

    idle_all();
    d1_m0_addr = '0; d1_m0_wdata = '0; d1_m0_we = 0; d1_m1_addr = '0; d1_m1_wdata = '0; d1_m1_we = 0;
    d3_m0_addr = '0; d3_m0_wdata = '0; d3_m0_we = 0; d3_m1_addr = '0; d3_m1_wdata = '0; d3_m1_we = 0;
    rst = 1'b0;
    ram_load(6'h10, 32'hDEADBEEF);
    ram_load(6'h08, 32'hCAFEF00D);
    ram_load(6'h09, 32'h0BADF00D);

    // Reset holds everything at zero even with a request pending.
    d1_m0_req = 1; d1_m0_addr = 32'h10; d1_m0_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ctrl", 64'({d1_m0_gnt, d1_m0_rvalid, d1_m1_gnt, d1_m1_rvalid, d1_mem_we, d1_busy}), 64'(0));
      chk("rst_bus", {d1_mem_addr, d1_mem_wdata}, 64'(0));
      chk("rst_rdata", {d1_m0_rdata, d1_m1_rdata}, 64'(0));
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) apply_txn(tbl[i]);

    // Contention: both read; port 1 keeps asking throughout.
    do_reset();
    d1_m0_addr = 32'h10; d1_m0_we = 0; d1_m1_addr = 32'h20; d1_m1_we = 0;
    d1_m0_req = 1; d1_m1_req = 1;
    for (int r = 0; r < 4; r++) begin
      logic ew;
      ew = RR ? 1'(r % 2) : 1'b0;
      tick();
      chk("cont_gnt", 64'({d1_m0_gnt, d1_m1_gnt}), 64'(ew ? 2'b01 : 2'b10));
      if (ew) d1_m1_req = 0; else d1_m0_req = 0;
      tick(); tick();
      chk("cont_rvalid", 64'({d1_m0_rvalid, d1_m1_rvalid}), 64'(ew ? 2'b01 : 2'b10));
      $display("txn contention round %0d expected winner %0d", r, ew);
      if (ew) d1_m1_req = 1; else d1_m0_req = 1;
    end
    d1_m0_req = 0;
    tick();
    chk("cont_p1_after", 64'({d1_m0_gnt, d1_m1_gnt}), 64'(2'b01));
    d1_m1_req = 0;
    tick(); tick(); tick();

    // Reset while a read waits on the RAM.
    d1_m0_req = 1; d1_m0_addr = 32'h10; d1_m0_we = 0;
    tick();
    d1_m0_req = 0;
    tick();
    chk("mid_busy_before", 64'(d1_busy), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_ctrl", 64'({d1_m0_rvalid, d1_busy, d1_mem_we}), 64'(0));
    chk("mid_rdata", 64'(d1_m0_rdata), 64'(0));
    tick();
    chk("mid_rvalid_rst", 64'(d1_m0_rvalid), 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rvalid_after", 64'({d1_m0_rvalid, d1_busy}), 64'(0));
    end
    $display("txn reset during read");

    // READ_LATENCY = 3: port 1 waits behind port 0's read.
    d3_m0_req = 1; d3_m0_addr = 32'h08; d3_m0_we = 0;
    d3_m1_req = 1; d3_m1_addr = 32'h09; d3_m1_we = 0;
    tick();
    chk("rl3_gnt", 64'({d3_m0_gnt, d3_m1_gnt}), 64'(2'b10));
    d3_m0_req = 0;
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("rl3_ctrl", 64'({d3_m1_gnt, d3_m0_rvalid, d3_busy}), 64'({1'b0, d == 4, d <= 3}));
    end
    chk("rl3_rdata0", 64'(d3_m0_rdata), 64'(32'hCAFEF00D));
    tick();
    chk("rl3_gnt1", 64'({d3_m0_gnt, d3_m1_gnt}), 64'(2'b01));
    d3_m1_req = 0;
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("rl3_rvalid1", 64'(d3_m1_rvalid), 64'(d == 4));
    end
    chk("rl3_rdata1", 64'(d3_m1_rdata), 64'(32'h0BADF00D));
    $display("txn latency-3 reads done");

    random_phase(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
